// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU.
// Grants at most one request per cycle and returns the registered result with its requester id.
module alu_share_arbiter #(
    parameter int WIDTH      = 32,
    parameter int CON_W      = 4,
    parameter int FIXED_PRIO = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [CON_W-1:0] req0_con,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [CON_W-1:0] req1_con,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [CON_W-1:0] alu_con,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_out,
    output logic             rsp_zero,
    output logic [15:0]      grant_cnt
);

    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req_a   [2];
    logic [WIDTH-1:0] req_b   [2];
    logic [CON_W-1:0] req_con [2];

    logic             rsp_valid_reg;
    logic             rsp_id_reg;
    logic [WIDTH-1:0] rsp_out_reg;
    logic             rsp_zero_reg;
    logic [15:0]      grant_cnt_reg;
    logic             last_grant_reg;

    logic             can_accept;
    logic             grant_vld;
    logic             grant_idx;

    assign req_valid  = {req1_valid, req0_valid};
    assign req_a[0]   = req0_a;
    assign req_a[1]   = req1_a;
    assign req_b[0]   = req0_b;
    assign req_b[1]   = req1_b;
    assign req_con[0] = req0_con;
    assign req_con[1] = req1_con;

    // The output register can take a new result when empty or being drained this cycle.
    assign can_accept = !rsp_valid_reg || rsp_ready;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 1'b0;
        if (!rst && can_accept) begin
            if (req_valid[0] && req_valid[1]) begin
                grant_vld = 1'b1;
                grant_idx = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_reg;
            end else if (req_valid[0]) begin
                grant_vld = 1'b1;
                grant_idx = 1'b0;
            end else if (req_valid[1]) begin
                grant_vld = 1'b1;
                grant_idx = 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = grant_vld && (grant_idx == 1'(gi));
        end
    endgenerate

    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];

    // Zeros on the ALU inputs when idle keep the shared datapath quiet.
    assign alu_a   = grant_vld ? req_a[grant_idx]   : '0;
    assign alu_b   = grant_vld ? req_b[grant_idx]   : '0;
    assign alu_con = grant_vld ? req_con[grant_idx] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_reg  <= 1'b0;
            rsp_id_reg     <= 1'b0;
            rsp_out_reg    <= '0;
            rsp_zero_reg   <= 1'b0;
            grant_cnt_reg  <= 16'd0;
            last_grant_reg <= 1'b1;
        end else if (grant_vld) begin
            rsp_valid_reg  <= 1'b1;
            rsp_id_reg     <= grant_idx;
            rsp_out_reg    <= alu_out;
            rsp_zero_reg   <= alu_zero;
            grant_cnt_reg  <= grant_cnt_reg + 16'd1;
            last_grant_reg <= grant_idx;
        end else if (rsp_valid_reg && rsp_ready) begin
            rsp_valid_reg  <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_out   = rsp_out_reg;
    assign rsp_zero  = rsp_zero_reg;
    assign grant_cnt = grant_cnt_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: a round-robin and a fixed-priority instance share the same stimulus,
// each with an XOR ALU stub.
module tb_alu_share_arbiter;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, rsp_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_con, req1_con;

    logic        d0_r0, d0_r1, d0_zin, d0_rv, d0_id, d0_z;
    logic [31:0] d0_alu_a, d0_alu_b, d0_aout, d0_out;
    logic [3:0]  d0_alu_con;
    logic [15:0] d0_cnt;

    logic        fp_r0, fp_r1, fp_zin, fp_rv, fp_id, fp_z;
    logic [31:0] fp_alu_a, fp_alu_b, fp_aout, fp_out;
    logic [3:0]  fp_alu_con;
    logic [15:0] fp_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign d0_aout = d0_alu_a ^ d0_alu_b;
    assign d0_zin  = (d0_aout == 32'h0);
    assign fp_aout = fp_alu_a ^ fp_alu_b;
    assign fp_zin  = (fp_aout == 32'h0);

    alu_share_arbiter #(.WIDTH(32), .CON_W(4), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(d0_r0), .req0_a(req0_a), .req0_b(req0_b), .req0_con(req0_con),
        .req1_valid(req1_valid), .req1_ready(d0_r1), .req1_a(req1_a), .req1_b(req1_b), .req1_con(req1_con),
        .alu_a(d0_alu_a), .alu_b(d0_alu_b), .alu_con(d0_alu_con), .alu_out(d0_aout), .alu_zero(d0_zin),
        .rsp_valid(d0_rv), .rsp_ready(rsp_ready), .rsp_id(d0_id), .rsp_out(d0_out), .rsp_zero(d0_z),
        .grant_cnt(d0_cnt)
    );

    alu_share_arbiter #(.WIDTH(32), .CON_W(4), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(fp_r0), .req0_a(req0_a), .req0_b(req0_b), .req0_con(req0_con),
        .req1_valid(req1_valid), .req1_ready(fp_r1), .req1_a(req1_a), .req1_b(req1_b), .req1_con(req1_con),
        .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_con(fp_alu_con), .alu_out(fp_aout), .alu_zero(fp_zin),
        .rsp_valid(fp_rv), .rsp_ready(rsp_ready), .rsp_id(fp_id), .rsp_out(fp_out), .rsp_zero(fp_z),
        .grant_cnt(fp_cnt)
    );

    typedef struct {
        logic        v0;
        logic [31:0] a0, b0;
        logic [3:0]  c0;
        logic        v1;
        logic [31:0] a1, b1;
        logic [3:0]  c1;
        logic        rr;
        logic        e_r0, e_r1;
        logic [31:0] e_alu_a;
        logic [3:0]  e_alu_con;
        logic        e_rv, e_id;
        logic [31:0] e_out;
        logic        e_zero;
        logic [15:0] e_cnt;
        logic        e_f0, e_f1, e_fid;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] c0,
                         input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] c1,
                         input logic rr);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_con = c0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_con = c1;
        rsp_ready  = rr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Stimulus | comb expectations (RR readies, ALU mux) | post-edge RR state | FP readies, FP id
        vecs[0]  = '{H,32'h3,32'h1,4'h2, L,32'h0,32'h0,4'h0, H,  H,L,32'h3,4'h2,  H,L,32'h2,L,16'd1,  H,L,L};
        vecs[1]  = '{H,32'h5,32'h5,4'h1, H,32'h7,32'h0,4'h3, H,  L,H,32'h7,4'h3,  H,H,32'h7,L,16'd2,  H,L,L};
        vecs[2]  = '{H,32'h5,32'h5,4'h1, H,32'h7,32'h0,4'h3, H,  H,L,32'h5,4'h1,  H,L,32'h0,H,16'd3,  H,L,L};
        vecs[3]  = '{H,32'h5,32'h5,4'h1, H,32'h7,32'h0,4'h3, H,  L,H,32'h7,4'h3,  H,H,32'h7,L,16'd4,  H,L,L};
        vecs[4]  = '{H,32'h5,32'h5,4'h1, H,32'h7,32'h0,4'h3, H,  H,L,32'h5,4'h1,  H,L,32'h0,H,16'd5,  H,L,L};
        vecs[5]  = '{L,32'h0,32'h0,4'h0, H,32'h7,32'h0,4'h3, L,  L,L,32'h0,4'h0,  H,L,32'h0,H,16'd5,  L,L,L};
        vecs[6]  = '{L,32'h0,32'h0,4'h0, H,32'h7,32'h0,4'h3, L,  L,L,32'h0,4'h0,  H,L,32'h0,H,16'd5,  L,L,L};
        vecs[7]  = '{L,32'h0,32'h0,4'h0, H,32'h7,32'h0,4'h3, L,  L,L,32'h0,4'h0,  H,L,32'h0,H,16'd5,  L,L,L};
        vecs[8]  = '{L,32'h0,32'h0,4'h0, H,32'h7,32'h0,4'h3, H,  L,H,32'h7,4'h3,  H,H,32'h7,L,16'd6,  L,H,H};
        vecs[9]  = '{L,32'h0,32'h0,4'h0, L,32'h0,32'h0,4'h0, H,  L,L,32'h0,4'h0,  L,H,32'h7,L,16'd6,  L,L,H};
        vecs[10] = '{L,32'h0,32'h0,4'h0, L,32'h0,32'h0,4'h0, L,  L,L,32'h0,4'h0,  L,H,32'h7,L,16'd6,  L,L,H};
        vecs[11] = '{H,32'h5,32'h5,4'h1, H,32'h7,32'h0,4'h3, H,  H,L,32'h5,4'h1,  H,L,32'h0,H,16'd7,  H,L,L};
        vecs[12] = '{L,32'h0,32'h0,4'h0, H,32'hFFFF0000,32'h0000FFFF,4'hF, H,
                     L,H,32'hFFFF0000,4'hF,  H,H,32'hFFFFFFFF,L,16'd8,  L,H,H};

        // Reset with both requests pending: no readies while rst is high.
        rst = 1'b1;
        drive(H, 32'h1, 32'h2, 4'h1, H, 32'h3, 32'h4, 4'h2, H);
        #2;
        chk("rst_r0", {31'b0, d0_r0}, 32'd0);
        chk("rst_r1", {31'b0, d0_r1}, 32'd0);
        tick();
        tick();
        chk("rst_rv",   {31'b0, d0_rv}, 32'd0);
        chk("rst_id",   {31'b0, d0_id}, 32'd0);
        chk("rst_out",  d0_out, 32'h0);
        chk("rst_zero", {31'b0, d0_z}, 32'd0);
        chk("rst_cnt",  {16'b0, d0_cnt}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].v0, vecs[i].a0, vecs[i].b0, vecs[i].c0,
                  vecs[i].v1, vecs[i].a1, vecs[i].b1, vecs[i].c1, vecs[i].rr);
            #2;
            chk("r0",      {31'b0, d0_r0}, {31'b0, vecs[i].e_r0});
            chk("r1",      {31'b0, d0_r1}, {31'b0, vecs[i].e_r1});
            chk("alu_a",   d0_alu_a, vecs[i].e_alu_a);
            chk("alu_con", {28'b0, d0_alu_con}, {28'b0, vecs[i].e_alu_con});
            chk("fp_r0",   {31'b0, fp_r0}, {31'b0, vecs[i].e_f0});
            chk("fp_r1",   {31'b0, fp_r1}, {31'b0, vecs[i].e_f1});
            tick();
            chk("rsp_valid", {31'b0, d0_rv}, {31'b0, vecs[i].e_rv});
            chk("rsp_id",    {31'b0, d0_id}, {31'b0, vecs[i].e_id});
            chk("rsp_out",   d0_out, vecs[i].e_out);
            chk("rsp_zero",  {31'b0, d0_z}, {31'b0, vecs[i].e_zero});
            chk("grant_cnt", {16'b0, d0_cnt}, {16'b0, vecs[i].e_cnt});
            chk("fp_rsp_id", {31'b0, fp_id}, {31'b0, vecs[i].e_fid});
            $display("vec %0d: rdy=%b%b rsp_valid=%b id=%b out=%h zero=%b cnt=%0d", i,
                     d0_r1, d0_r0, d0_rv, d0_id, d0_out, d0_z, d0_cnt);
        end

        // Reset mid-operation with a result pending and both requesters valid.
        drive(H, 32'h5, 32'h5, 4'h1, H, 32'h7, 32'h0, 4'h3, L);
        rst = 1'b1;
        #2;
        chk("midrst_r0",    {31'b0, d0_r0}, 32'd0);
        chk("midrst_r1",    {31'b0, d0_r1}, 32'd0);
        chk("midrst_fp_r0", {31'b0, fp_r0}, 32'd0);
        tick();
        chk("midrst_rv",  {31'b0, d0_rv}, 32'd0);
        chk("midrst_cnt", {16'b0, d0_cnt}, 32'd0);
        rst = 1'b0;
        rsp_ready = H;
        #2;
        chk("postrst_r0", {31'b0, d0_r0}, 32'd1);
        chk("postrst_r1", {31'b0, d0_r1}, 32'd0);
        tick();
        chk("postrst_id",  {31'b0, d0_id}, 32'd0);
        chk("postrst_cnt", {16'b0, d0_cnt}, 32'd1);
        $display("reset mid-op: rsp_valid=%b id=%b cnt=%0d", d0_rv, d0_id, d0_cnt);

        // Counter wrap: 65535 grants after reset, then two more.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(H, 32'h9, 32'h1, 4'h0, L, 32'h0, 32'h0, 4'h0, H);
        for (int i = 0; i < 65535; i++) tick();
        chk("cnt_ffff", {16'b0, d0_cnt}, 32'h0000FFFF);
        tick();
        chk("cnt_wrap0", {16'b0, d0_cnt}, 32'd0);
        tick();
        chk("cnt_wrap1", {16'b0, d0_cnt}, 32'd1);
        chk("wrap_out",  d0_out, 32'h8);
        $display("counter wrap: cnt=%0d out=%h", d0_cnt, d0_out);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU (operands A, B; 4-bit op select; 32-bit result; zero flag) between two requesters, e.g. the execute stage (port 0) and the branch/address unit (port 1).
- Arbitrates per cycle and drives the ALU inputs for the granted request.
- Captures the ALU result into one output register.
- Returns the result with a valid/ready handshake tagged by requester ID.

Parameters:
- WIDTH, 32, operand/result width.
- CON_W, 4, ALU op-select width.
- FIXED_PRIO, 0, 0 = round-robin; 1 = requester 0 always wins.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 accepted this cycle.
- req0_a  input  WIDTH  requester 0 operand A.
- req0_b  input  WIDTH  requester 0 operand B.
- req0_con  input  CON_W  requester 0 op select.
- req1_valid, req1_ready, req1_a, req1_b, req1_con: same as port 0, for requester 1.
- alu_a  output  WIDTH  to ALU operand A.
- alu_b  output  WIDTH  to ALU operand B.
- alu_con  output  CON_W  to ALU op select.
- alu_out  input  WIDTH  ALU result (combinational from alu_a/alu_b/alu_con).
- alu_zero  input  1  ALU zero flag.
- rsp_valid  output  1  result register holds a result.
- rsp_ready  input  1  consumer takes the result.
- rsp_id  output  1  requester that owns the result.
- rsp_out  output  WIDTH  registered ALU result.
- rsp_zero  output  1  registered zero flag.
- grant_cnt  output  16  total accepted operations; wraps at 16'hFFFF to 0.

Behaviour:
- Reset (synchronous, rst=1 at edge):
  - rsp_valid=0, rsp_id=0, rsp_out=0, rsp_zero=0, grant_cnt=0.
  - last_grant=1, so requester 0 wins the first contention.
  - A result pending at reset is dropped; no handshake completes in a reset cycle.
  - While rst=1, req0_ready=req1_ready=0.
- can_accept = !rsp_valid || rsp_ready (combinational). Same-cycle drain and refill is allowed, giving full throughput of one op per cycle.
- Grant logic (combinational, only when can_accept and !rst):
  - Only one valid: grant it.
  - Both valid, FIXED_PRIO=0: grant the requester != last_grant.
  - Both valid, FIXED_PRIO=1: grant requester 0.
  - No valid, or !can_accept: no grant.
- reqN_ready = grant to N. Ready may depend on valid. Requesters must not make valid depend on ready, and must hold operands stable while valid && !ready.
- ALU mux:
  - While a grant is active, alu_a/alu_b/alu_con = the granted requester's fields.
  - With no grant, drive all zeros; ALU result is ignored.
- On the edge ending a granted cycle:
  - rsp_out <= alu_out; rsp_zero <= alu_zero; rsp_id <= granted index; rsp_valid <= 1.
  - last_grant <= granted index; grant_cnt <= grant_cnt + 1.
- On an edge with rsp_valid && rsp_ready and no grant: rsp_valid <= 0. rsp_out/rsp_zero/rsp_id hold their last values.
- Back-pressure: while rsp_valid && !rsp_ready, no grants, and rsp_* are held stable.
- Latency: a request accepted in cycle N has its response visible (rsp_valid=1) in cycle N+1.
- last_grant changes only on grants. Idle cycles do not rotate priority.

Test Plan:
- Bench ALU stub: alu_out = alu_a ^ alu_b; alu_zero = (alu_out == 0).
1. Reset, then req0 only (a=32'h3, b=32'h1, con=4'h2), rsp_ready=1 -> req0_ready=1 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_out=32'h2, rsp_zero=0, grant_cnt=1.
2. Both valid continuously (req0 a=b=5; req1 a=7, b=0), rsp_ready=1, FIXED_PRIO=0 -> grants alternate 0,1,0,1. Responses: id0 out=0 zero=1; id1 out=7 zero=0. grant_cnt increments by 1 every cycle.
3. Same stimulus as scenario 2 with FIXED_PRIO=1 -> req1_ready never asserts; every response has rsp_id=0.
4. Back-pressure: result pending, rsp_ready=0 for 3 cycles with req1 valid -> req1_ready=0 all 3 cycles; rsp_* stable. Cycle with rsp_ready=1 -> req1 granted the same cycle; next cycle holds the req1 result.
5. Reset mid-operation: rsp_valid=1 and both requests valid, assert rst for 1 cycle -> next cycle rsp_valid=0, grant_cnt=0, no readies during rst; first post-reset contention grants requester 0.
6. Counter wrap: run 65536 accepted ops -> grant_cnt returns to 0 and continues to 1 on the next grant.
